// File: rtl/miniled_pkg.sv
// Shared definitions for the mini-LED zone frame writer: display modes and FSM encoding.
package miniled_pkg;

  localparam logic [1:0] MODE_LOCAL   = 2'd0;
  localparam logic [1:0] MODE_ALL_ON  = 2'd1;
  localparam logic [1:0] MODE_ALL_OFF = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/miniled_gray_map.sv
// Combinational brightness-to-gray mapping: global gain (x*gain/256, floor) then
// MSB replication up to the driver gray width. The parent registers the result.
module miniled_gray_map #(
  parameter int LIGHT_W = 8,
  parameter int GRAY_W  = 16
) (
  input  logic [LIGHT_W-1:0] I_v,
  input  logic [7:0]         I_gain,
  output logic [GRAY_W-1:0]  O_gray
);

  logic [LIGHT_W+7:0] prod;
  logic [LIGHT_W-1:0] s;

  // Product is sized LIGHT_W+8 so it can never overflow; the top LIGHT_W bits are v*gain/256.
  assign prod = {8'd0, I_v} * {{LIGHT_W{1'b0}}, I_gain};
  assign s    = prod[LIGHT_W+7:8];

  generate
    if (GRAY_W == LIGHT_W) begin : g_same
      assign O_gray = s;
    end else begin : g_expand
      assign O_gray = {s, s[LIGHT_W-1 -: GRAY_W-LIGHT_W]};
    end
  endgenerate

endmodule

// File: rtl/miniled_zone_frame_writer.sv
// Snapshots per-zone brightness, applies mode and gain, and streams one (addr, gray)
// write per zone over valid/ready. Back-to-back frames are supported via one pending slot.
module miniled_zone_frame_writer
  import miniled_pkg::*;
#(
  parameter int ZONES      = 360,
  parameter int COLS       = 24,
  parameter int LIGHT_W    = 8,
  parameter int GRAY_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int ADDR_BASE  = 0,
  parameter bit SERPENTINE = 1'b0
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic [ZONES*LIGHT_W-1:0] I_led_light,
  input  logic [1:0]               I_led_mode,
  input  logic [7:0]               I_gain,
  input  logic                     I_frame_start,
  input  logic                     I_wr_ready,
  output logic                     O_wr_valid,
  output logic                     O_sof,
  output logic [ADDR_W-1:0]        O_wr_addr,
  output logic [GRAY_W-1:0]        O_wr_data,
  output logic                     O_busy,
  output logic                     O_frame_done,
  output logic [7:0]               O_drop_cnt
);

  localparam int ROWS  = ZONES / COLS;
  localparam int IDX_W = $clog2(ZONES);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  state_e                   state_q, state_d;
  logic [ZONES*LIGHT_W-1:0] light_q, light_d;
  logic [1:0]               mode_q, mode_d;
  logic [7:0]               gain_q, gain_d;
  logic                     parity_q, parity_d;
  logic                     pending_q, pending_d;
  logic [7:0]               drop_q, drop_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ADDR_W-1:0]        rb_q, rb_d;
  logic                     valid_q, valid_d;
  logic                     sof_q, sof_d;
  logic                     done_q, done_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [GRAY_W-1:0]        data_q, data_d;

  logic                     start, advance, xfer, last;
  logic [LIGHT_W-1:0]       src_v, v_sel;
  logic [1:0]               src_mode;
  logic [7:0]               src_gain;
  logic [COL_W-1:0]         colp;
  logic [GRAY_W-1:0]        gray_next;

  assign xfer = valid_q & I_wr_ready;
  assign last = xfer & (idx_q == IDX_W'(ZONES - 1));

  // FSM, request bookkeeping and zone/row/col counter advance.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    light_d   = light_q;
    mode_d    = mode_q;
    gain_d    = gain_q;
    parity_d  = parity_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    rb_d      = rb_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    done_d    = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_frame_start || pending_q) begin
          start     = 1'b1;
          pending_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (last) begin
          done_d    = 1'b1;
          pending_d = I_frame_start;
          if (pending_q) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            sof_d   = 1'b0;
          end
        end else begin
          advance = xfer;
          if (I_frame_start) begin
            if (!pending_q)            pending_d = 1'b1;
            else if (drop_q != 8'hFF)  drop_d    = drop_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_SEND;
      light_d  = I_led_light;
      mode_d   = I_led_mode;
      gain_d   = I_gain;
      parity_d = ~parity_q;
      idx_d    = '0;
      row_d    = '0;
      col_d    = '0;
      rb_d     = '0;
      valid_d  = 1'b1;
      sof_d    = 1'b1;
    end else if (advance) begin
      light_d = light_q >> LIGHT_W;
      idx_d   = idx_q + 1'b1;
      sof_d   = 1'b0;
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
        rb_d  = rb_q + ADDR_W'(COLS);
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Value and address of the beat to present next (new frame's zone 0, or the following zone).
  always_comb begin
    src_v    = start ? I_led_light[LIGHT_W-1:0] : light_q[LIGHT_W +: LIGHT_W];
    src_mode = start ? I_led_mode : mode_q;
    src_gain = start ? I_gain : gain_q;
    case (src_mode)
      MODE_LOCAL:   v_sel = src_v;
      MODE_ALL_ON:  v_sel = '1;
      MODE_ALL_OFF: v_sel = '0;
      default:      v_sel = (row_d[0] ^ col_d[0] ^ parity_d) ? '1 : '0;
    endcase
    colp   = (SERPENTINE && row_d[0]) ? (COL_W'(COLS - 1) - col_d) : col_d;
    addr_d = (start || advance) ? (ADDR_W'(ADDR_BASE) + rb_d + ADDR_W'(colp)) : addr_q;
  end

  miniled_gray_map #(
    .LIGHT_W (LIGHT_W),
    .GRAY_W  (GRAY_W)
  ) u_gray_map (
    .I_v    (v_sel),
    .I_gain (src_gain),
    .O_gray (gray_next)
  );

  // Output data only updates when a new beat is presented, so it holds while stalled.
  always_comb begin
    data_d = (start || advance) ? gray_next : data_q;
  end

  // Control state, counters and registered outputs with synchronous reset.
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (I_rst) begin
      state_q   <= ST_IDLE;
      parity_q  <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rb_q      <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      parity_q  <= parity_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rb_q      <= rb_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Frame snapshot registers.
  always_ff @(posedge I_clk) begin
    // NOTE: the wide snapshot is not reset; it is always loaded at frame start before being read.
    light_q <= light_d;
    mode_q  <= mode_d;
    gain_q  <= gain_d;
  end

  assign O_wr_valid   = valid_q;
  assign O_sof        = sof_q;
  assign O_wr_addr    = addr_q;
  assign O_wr_data    = data_q;
  assign O_busy       = (state_q == ST_SEND);
  assign O_frame_done = done_q;
  assign O_drop_cnt   = drop_q;

endmodule

// File: tb/tb_miniled_zone_frame_writer.sv
// Directed bench for miniled_zone_frame_writer: linear and serpentine addressing,
// gain/mode mapping, stall stability, checker parity, pending/drop handling and reset.
module tb_miniled_zone_frame_writer;

  localparam int ZONES = 360;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ZONES*8-1:0] light = '0;
  logic [1:0]        mode = 2'd0;
  logic [7:0]        gain = 8'hFF;
  logic              fstart = 1'b0;
  logic              wr_ready = 1'b1;

  logic              o_valid, o_sof, o_busy, o_done;
  logic [9:0]        o_addr;
  logic [15:0]       o_data;
  logic [7:0]        o_drop;
  logic              s_valid, s_sof, s_busy, s_done;
  logic [9:0]        s_addr;
  logic [15:0]       s_data;
  logic [7:0]        s_drop;

  int checks = 0;
  int errors = 0;

  logic [9:0]  b_addr   [ZONES];
  logic [9:0]  b_addr_s [ZONES];
  logic [15:0] b_data   [ZONES];
  logic        b_sof    [ZONES];

  always #20 clk = ~clk;

  miniled_zone_frame_writer dut (
    .I_clk(clk), .I_rst(rst), .I_led_light(light), .I_led_mode(mode), .I_gain(gain),
    .I_frame_start(fstart), .I_wr_ready(wr_ready),
    .O_wr_valid(o_valid), .O_sof(o_sof), .O_wr_addr(o_addr), .O_wr_data(o_data),
    .O_busy(o_busy), .O_frame_done(o_done), .O_drop_cnt(o_drop)
  );

  miniled_zone_frame_writer #(.SERPENTINE(1'b1)) dut_s (
    .I_clk(clk), .I_rst(rst), .I_led_light(light), .I_led_mode(mode), .I_gain(gain),
    .I_frame_start(fstart), .I_wr_ready(wr_ready),
    .O_wr_valid(s_valid), .O_sof(s_sof), .O_wr_addr(s_addr), .O_wr_data(s_data),
    .O_busy(s_busy), .O_frame_done(s_done), .O_drop_cnt(s_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference gray value for an 8-bit zone and gain, expanded to 16 bits.
  function automatic logic [15:0] ref_gray(input int v, input int g);
    logic [7:0] s;
    s = 8'((v * g) >> 8);
    return {s, s};
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 fstart = 1'b1;
    @(posedge clk); #1 fstart = 1'b0;
  endtask

  // Record every accepted beat of one frame; counts addr/data changes while stalled.
  task automatic collect_frame(input bit rnd, output int n, output int stall_err);
    logic [9:0]  hold_a;
    logic [15:0] hold_d;
    bit          holding;
    n = 0; stall_err = 0; holding = 1'b0; hold_a = '0; hold_d = '0;
    for (int cyc = 0; cyc < 4000 && n < ZONES; cyc++) begin
      @(negedge clk);
      if (holding && (!o_valid || o_addr !== hold_a || o_data !== hold_d)) stall_err++;
      holding = 1'b0;
      if (o_valid && wr_ready) begin
        b_addr[n] = o_addr; b_addr_s[n] = s_addr; b_data[n] = o_data; b_sof[n] = o_sof;
        n++;
      end else if (o_valid) begin
        holding = 1'b1; hold_a = o_addr; hold_d = o_data;
      end
      if (n < ZONES) begin
        @(posedge clk); #1 wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  endtask

  initial begin
    int n, serr, bad, sofbad, c;
    bit seen;
    logic [15:0] z0;

    for (int i = 0; i < ZONES; i++) light[i*8 +: 8] = 8'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_drop",  o_drop, 0);
    check("rst_done",  o_done, 0);
    check("rst_sof",   o_sof, 0);
    check("rst_addr",  o_addr, 0);
    check("rst_data",  o_data, 0);

    // Test 1/2: mode 0, unity-ish gain, ready always high; serpentine instance in parallel
    mode = 2'd0; gain = 8'hFF; wr_ready = 1'b1;
    pulse_start();
    collect_frame(1'b0, n, serr);
    check("t1_beats", n, ZONES);
    check("t1_sof0", b_sof[0], 1);
    check("t1_addr0", b_addr[0], 0);
    check("t1_addr359", b_addr[359], 359);
    check("t1_data359", b_data[359], 16'h6666);
    check("t1_data200", b_data[200], 16'hC7C7);
    bad = 0; sofbad = 0;
    for (int i = 0; i < ZONES; i++) begin
      if (b_addr[i] !== 10'(i) || b_data[i] !== ref_gray(i % 256, 255)) bad++;
      if (i > 0 && b_sof[i] !== 1'b0) sofbad++;
    end
    check("t1_beat_errs", bad, 0);
    check("t1_sof_errs", sofbad, 0);
    check("t2_serp_addr0", b_addr_s[0], 0);
    check("t2_serp_addr24", b_addr_s[24], 47);
    check("t2_serp_addr47", b_addr_s[47], 24);
    check("t2_serp_addr48", b_addr_s[48], 48);
    @(negedge clk);
    check("t1_done", o_done, 1);
    check("t1_valid_after", o_valid, 0);
    @(negedge clk);
    check("t1_done_pulse", o_done, 0);
    check("t1_busy_after", o_busy, 0);

    // Test 3: mode 1, gain 128, random ready
    mode = 2'd1; gain = 8'd128;
    pulse_start();
    collect_frame(1'b1, n, serr);
    check("t3_beats", n, ZONES);
    check("t3_stall", serr, 0);
    bad = 0;
    for (int i = 0; i < ZONES; i++)
      if (b_data[i] !== 16'h7F7F || b_addr[i] !== 10'(i)) bad++;
    check("t3_beat_errs", bad, 0);
    @(negedge clk);
    check("t3_done", o_done, 1);
    #1 wr_ready = 1'b1;

    // Test 4: checker mode on two frames; parity was toggled by the two frames above
    mode = 2'd3; gain = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      z0 = (f == 0) ? 16'hFEFE : 16'h0000;
      pulse_start();
      collect_frame(1'b0, n, serr);
      check("t4_zone0", b_data[0], z0);
      check("t4_zone1", b_data[1], (f == 0) ? 16'h0000 : 16'hFEFE);
      check("t4_zone24", b_data[24], (f == 0) ? 16'h0000 : 16'hFEFE);
      check("t4_zone25", b_data[25], z0);
      @(negedge clk);
    end

    // Test 5: pending frame and saturating drop counter
    mode = 2'd0;
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    pulse_start();
    @(negedge clk);
    check("t5_drop1", o_drop, 1);
    check("t5_busy", o_busy, 1);
    seen = 1'b0;
    for (c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check("t5_done_seen", seen, 1);
    check("t5_b2b_valid", o_valid, 1);
    check("t5_b2b_sof", o_sof, 1);
    check("t5_b2b_addr", o_addr, 0);
    @(posedge clk); #1 wr_ready = 1'b0;
    repeat (300) pulse_start();
    @(negedge clk);
    check("t5_drop_sat", o_drop, 255);
    check("t5_busy_stall", o_busy, 1);
    #1 wr_ready = 1'b1;
    seen = 1'b0;
    for (c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (!o_busy) seen = 1'b1;
    end
    check("t5_idle_again", seen, 1);

    // Test 6: reset mid-frame, then clean restart with a fresh snapshot
    pulse_start();
    seen = 1'b0;
    for (c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (o_valid && o_addr == 10'd100) seen = 1'b1;
    end
    check("t6_reach100", seen, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_valid", o_valid, 0);
    check("t6_busy", o_busy, 0);
    check("t6_drop", o_drop, 0);
    check("t6_done", o_done, 0);
    light[7:0] = 8'd200; mode = 2'd0; gain = 8'hFF;
    @(posedge clk); #1 fstart = 1'b1;
    @(posedge clk); #1 fstart = 1'b0; gain = 8'd0; mode = 2'd2; light[15:8] = 8'd0;
    collect_frame(1'b0, n, serr);
    check("t6_beats", n, ZONES);
    check("t6_sof0", b_sof[0], 1);
    check("t6_addr0", b_addr[0], 0);
    check("t6_data0", b_data[0], 16'hC7C7);
    check("t6_data1", b_data[1], 16'h0000);
    check("t6_data5", b_data[5], 16'h0404);
    @(negedge clk);
    check("t6_done", o_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
